// File: rtl/uni_shift_register_if.sv
// uni_shift_register_if
//   Bundles the control/data bus of uni_shift_register.
//   master : drives i_en, i_mode, i_par, i_ser_l, i_ser_r; observes outputs
//   slave  : the shift register itself
//   Signals:
//     i_en     operation enable
//     i_mode   3-bit operation select
//     i_par    parallel load data (WIDTH)
//     i_ser_l  serial in, enters bit 0 on shift left
//     i_ser_r  serial in, enters bit WIDTH-1 on logical shift right
//     o_par    register contents (WIDTH)
//     o_ser_l  last bit shifted/rotated out of bit WIDTH-1
//     o_ser_r  last bit shifted/rotated out of bit 0
//     o_cnt    shifts since last load/clear/wrap (CNT_W)
//     o_done   one-cycle frame completion pulse
interface uni_shift_register_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic             i_en;
   logic [2:0]       i_mode;
   logic [WIDTH-1:0] i_par;
   logic             i_ser_l;
   logic             i_ser_r;
   logic [WIDTH-1:0] o_par;
   logic             o_ser_l;
   logic             o_ser_r;
   logic [CNT_W-1:0] o_cnt;
   logic             o_done;

   modport master (
      output i_en, i_mode, i_par, i_ser_l, i_ser_r,
      input  o_par, o_ser_l, o_ser_r, o_cnt, o_done
   );

   modport slave (
      input  i_en, i_mode, i_par, i_ser_l, i_ser_r,
      output o_par, o_ser_l, o_ser_r, o_cnt, o_done
   );
endinterface

// File: rtl/uni_shift_register.sv
// uni_shift_register
//   Parametrised universal shift register: load, logical shift left/right,
//   rotate left/right, arithmetic shift right, clear and hold. A per-frame
//   counter pulses o_done for one cycle after every WIDTH shift/rotate
//   operations, so the block can serialize/deserialize without an
//   external counter.
//   Ports:
//     i_clk   clock, rising edge
//     i_rstn  synchronous active-low reset (priority over everything)
//     bus     uni_shift_register_if.slave (see interface header)
module uni_shift_register #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   uni_shift_register_if.slave   bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'd0,
      MODE_LOAD = 3'd1,
      MODE_SHL  = 3'd2,
      MODE_SHR  = 3'd3,
      MODE_ROL  = 3'd4,
      MODE_ROR  = 3'd5,
      MODE_ASR  = 3'd6,
      MODE_CLR  = 3'd7
   } mode_e;

   logic [WIDTH-1:0] par_q;
   logic             ser_l_q;
   logic             ser_r_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   mode_e mode;
   logic  is_shift;

   assign mode     = mode_e'(bus.i_mode);
   assign is_shift = (mode inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR});

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         par_q   <= RST_VAL;
         ser_l_q <= 1'b0;
         ser_r_q <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         // done is a pulse: cleared on every cycle that is not a wrapping shift
         done_q <= 1'b0;
         if (bus.i_en) begin
            case (mode)
               MODE_HOLD: ;
               MODE_LOAD: begin
                  par_q <= bus.i_par;
                  cnt_q <= '0;
               end
               MODE_SHL: begin
                  par_q   <= {par_q[WIDTH-2:0], bus.i_ser_l};
                  ser_l_q <= par_q[WIDTH-1];
               end
               MODE_SHR: begin
                  par_q   <= {bus.i_ser_r, par_q[WIDTH-1:1]};
                  ser_r_q <= par_q[0];
               end
               MODE_ROL: begin
                  par_q   <= {par_q[WIDTH-2:0], par_q[WIDTH-1]};
                  ser_l_q <= par_q[WIDTH-1];
               end
               MODE_ROR: begin
                  par_q   <= {par_q[0], par_q[WIDTH-1:1]};
                  ser_r_q <= par_q[0];
               end
               MODE_ASR: begin
                  par_q   <= {par_q[WIDTH-1], par_q[WIDTH-1:1]};
                  ser_r_q <= par_q[0];
               end
               MODE_CLR: begin
                  par_q   <= RST_VAL;
                  cnt_q   <= '0;
                  ser_l_q <= 1'b0;
                  ser_r_q <= 1'b0;
               end
               default: ;
            endcase

            if (is_shift) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q  <= '0;
                  done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end
      end
   end

   assign bus.o_par   = par_q;
   assign bus.o_ser_l = ser_l_q;
   assign bus.o_ser_r = ser_r_q;
   assign bus.o_cnt   = cnt_q;
   assign bus.o_done  = done_q;
endmodule

// File: tb/tb_uni_shift_register.sv
// tb_uni_shift_register
//   Directed scenarios followed by random stimulus, every cycle compared
//   against an arithmetic reference model of the register.
module tb_uni_shift_register;
   localparam int unsigned WIDTH = 8;

   logic i_clk;
   logic i_rstn;

   uni_shift_register_if #(.WIDTH(WIDTH)) bus ();

   uni_shift_register #(.WIDTH(WIDTH), .RST_VAL(8'h00)) dut (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .bus    (bus.slave)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int unsigned n_tests;
   int unsigned n_fail;

   // reference model state
   int unsigned m_par;
   int unsigned m_ser_l;
   int unsigned m_ser_r;
   int unsigned m_cnt;
   int unsigned m_done;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic rstn, input logic en, input logic [2:0] mode,
                             input logic [7:0] par, input logic sl, input logic sr);
      if (!rstn) begin
         m_par = 0; m_ser_l = 0; m_ser_r = 0; m_cnt = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (en) begin
            case (mode)
               3'd1: begin m_par = par; m_cnt = 0; end
               3'd2: begin m_ser_l = m_par / 128; m_par = ((m_par * 2) + sl) % 256; end
               3'd3: begin m_ser_r = m_par % 2; m_par = (m_par / 2) + (sr * 128); end
               3'd4: begin m_ser_l = m_par / 128; m_par = ((m_par * 2) % 256) + (m_par / 128); end
               3'd5: begin m_ser_r = m_par % 2; m_par = (m_par / 2) + ((m_par % 2) * 128); end
               3'd6: begin m_ser_r = m_par % 2; m_par = (m_par / 2) + (m_par / 128) * 128; end
               3'd7: begin m_par = 0; m_cnt = 0; m_ser_l = 0; m_ser_r = 0; end
               default: ;
            endcase
            if (mode >= 3'd2 && mode <= 3'd6) begin
               if (m_cnt == WIDTH - 1) begin m_cnt = 0; m_done = 1; end
               else m_cnt++;
            end
         end
      end
   endtask

   // one clock: drive, step the model at the edge, compare shortly after
   task automatic cyc(input logic rstn, input logic en, input logic [2:0] mode,
                      input logic [7:0] par, input logic sl, input logic sr);
      i_rstn      = rstn;
      bus.i_en    = en;
      bus.i_mode  = mode;
      bus.i_par   = par;
      bus.i_ser_l = sl;
      bus.i_ser_r = sr;
      @(posedge i_clk);
      model_step(rstn, en, mode, par, sl, sr);
      #1;
      check("par",   bus.o_par,   m_par);
      check("ser_l", bus.o_ser_l, m_ser_l);
      check("ser_r", bus.o_ser_r, m_ser_r);
      check("cnt",   bus.o_cnt,   m_cnt);
      check("done",  bus.o_done,  m_done);
   endtask

   task automatic op(input logic [2:0] mode, input logic [7:0] par, input logic sl, input logic sr);
      cyc(1'b1, 1'b1, mode, par, sl, sr);
   endtask

   logic [7:0] pat;
   int unsigned dones;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      m_par = 0; m_ser_l = 0; m_ser_r = 0; m_cnt = 0; m_done = 0;
      i_rstn = 1'b0;
      bus.i_en = 1'b0; bus.i_mode = 3'd0; bus.i_par = '0;
      bus.i_ser_l = 1'b0; bus.i_ser_r = 1'b0;

      // reset with conflicting load request
      repeat (2) cyc(1'b0, 1'b1, 3'd1, 8'hFF, 1'b1, 1'b1);
      check("rst_par", bus.o_par, 8'h00);
      check("rst_cnt", bus.o_cnt, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_ser", {bus.o_ser_l, bus.o_ser_r}, 0);

      // serializer
      pat = 8'hA5;
      op(3'd1, pat, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         op(3'd2, 8'h00, 1'b0, 1'b0);
         check("sers_bit", bus.o_ser_l, pat[7-i]);
         check("sers_done", bus.o_done, (i == 7) ? 1 : 0);
      end
      check("sers_par", bus.o_par, 8'h00);
      check("sers_cnt", bus.o_cnt, 0);

      // deserializer
      pat = 8'h3C;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         op(3'd3, 8'h00, 1'b0, pat[i]);
         dones += bus.o_done;
      end
      check("des_par", bus.o_par, 8'h3C);
      check("des_dones", dones, 1);

      // rotates and arithmetic shift
      op(3'd1, 8'h81, 1'b0, 1'b0);
      op(3'd5, 8'h00, 1'b0, 1'b0);
      check("ror", bus.o_par, 8'hC0);
      op(3'd4, 8'h00, 1'b0, 1'b0);
      check("rol", bus.o_par, 8'h81);
      repeat (8) op(3'd4, 8'h00, 1'b0, 1'b0);
      check("rol8", bus.o_par, 8'h81);
      op(3'd1, 8'h80, 1'b0, 1'b0);
      repeat (3) op(3'd6, 8'h00, 1'b0, 1'b0);
      check("asr", bus.o_par, 8'hF0);
      check("asr_ser_r", bus.o_ser_r, 0);

      // enable low and HOLD
      op(3'd1, 8'h5A, 1'b0, 1'b0);
      repeat (3) op(3'd2, 8'h00, 1'b0, 1'b0);
      repeat (4) begin
         cyc(1'b1, 1'b0, 3'd2, 8'hFF, 1'b1, 1'b1);
         check("en0_cnt", bus.o_cnt, 3);
         check("en0_par", bus.o_par, 8'hD0);
      end
      repeat (2) begin
         op(3'd0, 8'hFF, 1'b1, 1'b1);
         check("hold_cnt", bus.o_cnt, 3);
         check("hold_par", bus.o_par, 8'hD0);
      end
      for (int i = 0; i < 5; i++) begin
         op(3'd2, 8'h00, 1'b0, 1'b0);
         check("hold_done", bus.o_done, (i == 4) ? 1 : 0);
      end

      // mid-frame restart, clear, reset
      dones = 0;
      repeat (5) begin op(3'd2, 8'h00, 1'b1, 1'b0); dones += bus.o_done; end
      op(3'd1, 8'h0F, 1'b0, 1'b0);
      repeat (7) begin op(3'd2, 8'h00, 1'b0, 1'b0); dones += bus.o_done; end
      check("restart_dones", dones, 0);
      check("restart_cnt", bus.o_cnt, 7);
      op(3'd7, 8'hFF, 1'b1, 1'b1);
      check("clr_par", bus.o_par, 8'h00);
      check("clr_cnt", bus.o_cnt, 0);
      repeat (7) op(3'd2, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
      check("rst_mid_done", bus.o_done, 0);
      check("rst_mid_cnt", bus.o_cnt, 0);
      op(3'd2, 8'h00, 1'b1, 1'b0);
      check("rst_mid_nodone", bus.o_done, 0);

      // random traffic, shift-heavy so frames complete
      for (int i = 0; i < 600; i++) begin
         logic [2:0] md;
         md = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 6));
         cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 4) != 0), md,
             8'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uni_shift_register.md
Name: uni_shift_register

Overview:
- Parametrised universal shift register, the generalised successor of the team's 8-bit load/shift block.
- Supports:
  - parallel load;
  - logical shift left/right;
  - rotate left/right;
  - arithmetic shift right;
  - clear;
  - hold.
- A per-frame shift counter asserts a one-cycle done pulse after WIDTH shift/rotate operations. The block can therefore act as a serializer or deserializer in the datapath without external counters.

Parameters:
- WIDTH, 8, register width in bits. Must be ≥ 2.
- RST_VAL, 0, reset and clear value of the data register, WIDTH bits.
- CNT_W, $clog2(WIDTH), derived localparam giving the width of o_cnt. Not overridable.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_en  in  1  operation enable. When 0, all state holds.
- i_mode  in  3  operation select; see Behaviour.
- i_par  in  WIDTH  parallel load data.
- i_ser_l  in  1  serial input entering bit 0 on shift left.
- i_ser_r  in  1  serial input entering bit WIDTH-1 on logical shift right.
- o_par  out  WIDTH  register contents.
- o_ser_l  out  1  last bit shifted/rotated out of bit WIDTH-1.
- o_ser_r  out  1  last bit shifted/rotated out of bit 0.
- o_cnt  out  CNT_W  shift operations since last load/clear/wrap.
- o_done  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset: i_rstn=0 sampled at a rising edge forces:
  - o_par=RST_VAL;
  - o_ser_l=0, o_ser_r=0;
  - o_cnt=0;
  - o_done=0.
- Reset has priority over i_en and i_mode. Reset in the middle of a frame discards the frame with no done pulse.
- All outputs are registered. The effect of a mode is visible one cycle after the edge at which it is sampled with i_en=1.
- i_en=0: all registers hold, except o_done, which returns to 0.
- i_mode encoding (applied when i_en=1), with D = o_par and N = WIDTH:
  - 0 HOLD: D unchanged, counter unchanged.
  - 1 LOAD: D=i_par, counter=0.
  - 2 SHL: D={D[N-2:0], i_ser_l}, o_ser_l=D[N-1].
  - 3 SHR: D={i_ser_r, D[N-1:1]}, o_ser_r=D[0].
  - 4 ROL: D={D[N-2:0], D[N-1]}, o_ser_l=D[N-1].
  - 5 ROR: D={D[0], D[N-1:1]}, o_ser_r=D[0].
  - 6 ASR: D={D[N-1], D[N-1:1]}, o_ser_r=D[0].
  - 7 CLR: D=RST_VAL, counter=0, o_ser_l=0, o_ser_r=0.
- Serial outputs:
  - The serial output not named for a mode holds its value.
  - LOAD and HOLD leave both serial outputs unchanged.
- Counter (modes 2–6 with i_en=1):
  - If o_cnt==WIDTH-1: o_cnt becomes 0 and o_done becomes 1 for exactly the next cycle.
  - Otherwise: o_cnt increments and o_done becomes 0.
- o_done is 0 after any cycle that is not a wrapping shift, including LOAD, CLR, HOLD and i_en=0.
- Back-to-back frames: consecutive wrapping shifts every WIDTH cycles produce one done pulse per frame with no gap cycles required.
- Rotation by WIDTH steps returns D to its original value.
- No unknown states: every mode code is defined, and the counter is always within 0..WIDTH-1.

Test Plan:
- Reset: drive i_rstn=0 for 2 cycles with i_en=1, i_mode=1, i_par=8'hFF -> o_par=8'h00, o_cnt=0, o_done=0, o_ser_l=0, o_ser_r=0.
- Serializer (WIDTH=8):
  - Stimulus: LOAD 8'hA5, then SHL ×8 with i_ser_l=0.
  - o_ser_l sequence: 1,0,1,0,0,1,0,1.
  - Final o_par=8'h00.
  - o_done=1 only in the cycle after the 8th shift; o_cnt=0 there.
- Deserializer: SHR ×8 with i_ser_r driven by the bits of 8'h3C, LSB first -> o_par=8'h3C and a single done pulse.
- Rotate and arithmetic shift:
  - LOAD 8'h81, ROR ×1 -> 8'hC0; ROL ×1 -> 8'h81.
  - ROL ×8 -> 8'h81.
  - LOAD 8'h80, ASR ×3 -> 8'hF0, o_ser_r=0.
- Enable and hold:
  - After LOAD 8'h5A and SHL ×3: toggle i_en=0 for 4 cycles, then mode 0 for 2 cycles -> o_par and o_cnt=3 unchanged throughout.
  - 5 more SHL -> done pulse.
- Mid-frame restart:
  - Stimulus: SHL ×5, LOAD 8'h0F, SHL ×7.
  - No done pulse; o_cnt=7.
  - CLR -> o_par=RST_VAL, o_cnt=0.
  - Synchronous reset mid-frame -> all outputs at reset values and no done pulse.
